// File: rtl/vernam_pkg.sv
// Shared Vernam cipher definitions: byte type, keystream LFSR step and FSM states.
// Used by both the encryptor and the receive-side decipher so the keystreams cannot drift apart.
package vernam_pkg;
  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Galois right-shift step; the output bit feeds back through the tap mask.
  function automatic byte_t lfsr_step(input byte_t k);
    return {1'b0, k[BYTE_W-1:1]} ^ (k[0] ? LFSR_TAPS : byte_t'(0));
  endfunction
endpackage

// File: rtl/vernam_deciph_rx_if.sv
// Ciphertext-in / plaintext-out valid-ready bundle for the Vernam receive stage.
// master = upstream producer plus downstream consumer side; slave = the decipher block.
interface vernam_deciph_rx_if;
  import vernam_pkg::*;

  byte_t ct_in;
  logic  ct_valid;
  logic  ct_last;
  logic  ct_ready;
  byte_t pt_out;
  logic  pt_valid;
  logic  pt_ready;

  modport master (
    output ct_in, ct_valid, ct_last, pt_ready,
    input  ct_ready, pt_out, pt_valid
  );

  modport slave (
    input  ct_in, ct_valid, ct_last, pt_ready,
    output ct_ready, pt_out, pt_valid
  );
endinterface

// File: rtl/vernam_byte_fifo.sv
// Byte FIFO with registered storage head; DEPTH a power of two >= 2.
// Latency: a push is visible at the head one cycle later. Backpressure: pushes while full and pops while empty are dropped.
module vernam_byte_fifo
  import vernam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  byte_t din,
  input  logic  pop,
  output byte_t dout,
  output logic  full,
  output logic  empty,
  output logic  single
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  byte_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign dout   = mem[rd_ptr];
  assign full   = (count == CNT_FULL);
  assign empty  = (count == '0);
  assign single = (count == CNT_ONE);
endmodule

// File: rtl/vernam_deciph_rx.sv
// Vernam receive stage: XORs ciphertext with a locally regenerated LFSR keystream, buffers plaintext.
// Latency: plaintext valid one cycle after ct accept into an empty FIFO. Backpressure: ct_ready drops when FIFO full or not in RUN.
// Optional VERNAM_RX_CHK_EN adds a per-frame XOR checksum output (chk_out/chk_valid).
module vernam_deciph_rx
  import vernam_pkg::*;
#(
  parameter byte_t SEED  = 8'hA5,
  parameter int    DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  vernam_deciph_rx_if.slave   bus,
  output logic                busy,
  output byte_t               key_dbg
`ifdef VERNAM_RX_CHK_EN
  ,
  output byte_t               chk_out,
  output logic                chk_valid
`endif
);
  state_t state, state_nxt;
  byte_t  lfsr, pt_byte;
  logic   fifo_full, fifo_empty, fifo_single;
  logic   accept, pop, frame_start, drain_done;

  assign frame_start  = (state == IDLE) & start;
  assign bus.ct_ready = (state == RUN) & ~fifo_full;
  assign accept       = bus.ct_valid & bus.ct_ready;
  assign bus.pt_valid = ~fifo_empty;
  assign pop          = bus.pt_valid & bus.pt_ready;
  assign pt_byte      = bus.ct_in ^ lfsr;
  // Final byte leaving this cycle counts as empty so DRAIN exits without an idle bubble.
  assign drain_done   = fifo_empty | (fifo_single & pop);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && bus.ct_last) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) lfsr <= SEED;
    else if (accept)        lfsr <= lfsr_step(lfsr);
  end

  vernam_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (accept),
    .din    (pt_byte),
    .pop    (pop),
    .dout   (bus.pt_out),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .single (fifo_single)
  );

  assign busy    = (state != IDLE);
  assign key_dbg = lfsr;

`ifdef VERNAM_RX_CHK_EN
  byte_t chk_acc;
  logic  chk_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc   <= '0;
      chk_pulse <= 1'b0;
    end else begin
      chk_pulse <= (state == DRAIN) & (state_nxt == IDLE);
      if (frame_start)  chk_acc <= '0;
      else if (accept)  chk_acc <= chk_acc ^ pt_byte;
    end
  end

  assign chk_out   = chk_acc;
  assign chk_valid = chk_pulse;
`endif
endmodule

// File: tb/tb_vernam_deciph_rx.sv
// Bench for vernam_deciph_rx: cycle table for the short corner cases, then queue-model scoreboarded frames.
module tb_vernam_deciph_rx;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic [7:0] key_dbg;
`ifdef VERNAM_RX_CHK_EN
  logic [7:0] chk_out;
  logic       chk_valid;
`endif

  vernam_deciph_rx_if bus();

  vernam_deciph_rx #(.SEED(8'hA5), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .key_dbg (key_dbg)
`ifdef VERNAM_RX_CHK_EN
    ,
    .chk_out   (chk_out),
    .chk_valid (chk_valid)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] keys [64];
  logic [7:0] frame_pt [$];

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    bus.ct_in = 8'h00;
    bus.ct_valid = 1'b0;
    bus.ct_last = 1'b0;
    bus.pt_ready = 1'b0;
  endtask

  // mode 0: consumer always ready; 1: random valid/ready; 2: consumer stalled for the first 8 cycles
  task automatic run_frame(input int mode);
    logic [7:0] q [$];
    logic [7:0] csum;
    int  n, idx, cyc;
    bit  done, pr, vld, push_now, pop_now;
    n = frame_pt.size();
    idx = 0; cyc = 0; done = 0; csum = 8'h00;
    chk1("idle_before_frame", busy, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cyc < 600) begin
      chk1("ct_ready", bus.ct_ready, (idx < n) && (q.size() < DEPTH));
      chk1("busy", busy, 1'b1);
      chk1("pt_valid", bus.pt_valid, q.size() != 0);
      chk8("key_dbg", key_dbg, keys[idx]);
`ifdef VERNAM_RX_CHK_EN
      chk1("chk_valid_quiet", chk_valid, 1'b0);
`endif
      case (mode)
        0:       pr = 1'b1;
        1:       pr = ($urandom_range(0, 2) != 0);
        default: pr = (cyc >= 8);
      endcase
      vld = (idx < n) && (mode != 1 || $urandom_range(0, 3) != 0);
      pop_now  = pr && (q.size() != 0);
      push_now = vld && (idx < n) && (q.size() < DEPTH);
      if (q.size() != 0) chk8("pt_out", bus.pt_out, q[0]);
      bus.pt_ready = pr;
      bus.ct_valid = vld;
      bus.ct_in    = vld ? (frame_pt[idx] ^ keys[idx]) : 8'($urandom);
      bus.ct_last  = vld && (idx == n - 1);
      @(posedge clk); #1;
      if (pop_now) void'(q.pop_front());
      if (push_now) begin
        q.push_back(frame_pt[idx]);
        csum ^= frame_pt[idx];
        idx++;
      end
      done = (idx == n) && (q.size() == 0);
      cyc++;
    end
    idle_inputs();
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: accepted %0d of %0d bytes, %0d buffered", idx, n, q.size());
    end
    chk1("busy_after_frame", busy, 1'b0);
    chk1("pt_valid_after_frame", bus.pt_valid, 1'b0);
    chk1("ct_ready_after_frame", bus.ct_ready, 1'b0);
`ifdef VERNAM_RX_CHK_EN
    chk1("chk_valid_pulse", chk_valid, 1'b1);
    chk8("chk_out", chk_out, csum);
    @(posedge clk); #1;
    chk1("chk_valid_one_cycle", chk_valid, 1'b0);
`endif
  endtask

  typedef struct {
    logic st, vld, last, prdy;
    logic [7:0] ct;
    logic e_crdy, e_pv;
    logic [7:0] e_pt;
    logic e_busy;
    logic [7:0] e_key;
  } vec_t;

  vec_t vt [9];

  initial begin
    // Outputs are checked first, then the row's inputs are applied for the next edge.
    vt[0] = '{1,0,0,0, 8'h00, 0,0, 8'h00, 0, 8'hA5};
    vt[1] = '{0,1,1,1, 8'hCD, 1,0, 8'h00, 1, 8'hA5};
    vt[2] = '{0,0,0,1, 8'h00, 0,1, 8'h68, 1, 8'hEA};
    vt[3] = '{1,0,0,0, 8'h00, 0,0, 8'h00, 0, 8'hEA};
    vt[4] = '{0,1,0,0, 8'hCD, 1,0, 8'h00, 1, 8'hA5};
    vt[5] = '{1,1,1,0, 8'h83, 1,1, 8'h68, 1, 8'hEA};
    vt[6] = '{1,0,0,1, 8'h00, 0,1, 8'h68, 1, 8'h75};
    vt[7] = '{0,0,0,1, 8'h00, 0,1, 8'h69, 1, 8'h75};
    vt[8] = '{0,0,0,0, 8'h00, 0,0, 8'h00, 0, 8'h75};

    keys[0] = 8'hA5;
    for (int i = 1; i < 64; i++)
      keys[i] = (keys[i-1] >> 1) ^ (keys[i-1][0] ? 8'hB8 : 8'h00);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk8("reset_pt_out", bus.pt_out, 8'h00);
    chk1("reset_pt_valid", bus.pt_valid, 1'b0);
    chk1("reset_ct_ready", bus.ct_ready, 1'b0);

    for (int i = 0; i < 9; i++) begin
      chk1($sformatf("vec%0d_ct_ready", i), bus.ct_ready, vt[i].e_crdy);
      chk1($sformatf("vec%0d_pt_valid", i), bus.pt_valid, vt[i].e_pv);
      if (vt[i].e_pv) chk8($sformatf("vec%0d_pt_out", i), bus.pt_out, vt[i].e_pt);
      chk1($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      chk8($sformatf("vec%0d_key", i), key_dbg, vt[i].e_key);
      start        = vt[i].st;
      bus.ct_valid = vt[i].vld;
      bus.ct_last  = vt[i].last;
      bus.pt_ready = vt[i].prdy;
      bus.ct_in    = vt[i].ct;
      @(posedge clk); #1;
    end
    idle_inputs();

    // "hi" frame: checksum 0x68 ^ 0x69 = 0x01
    frame_pt = '{8'h68, 8'h69};
    run_frame(0);

    frame_pt = '{"h","e","l","l","o","w","o","r","l","d","2"};
    run_frame(0);

    // Five bytes into a four-deep FIFO with the consumer stalled
    frame_pt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame(2);

    // Reset with two bytes buffered mid-frame
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.ct_valid = 1'b1;
    bus.ct_in = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    chk1("pre_reset_pt_valid", bus.pt_valid, 1'b1);
    bus.ct_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("midreset_pt_valid", bus.pt_valid, 1'b0);
    chk1("midreset_busy", busy, 1'b0);
    chk1("midreset_ct_ready", bus.ct_ready, 1'b0);
    chk8("midreset_key", key_dbg, 8'hA5);
    frame_pt = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(0);

    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, 20);
      frame_pt.delete();
      for (int b = 0; b < len; b++) frame_pt.push_back(8'($urandom));
      run_frame(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vernam_deciph_rx.md
Name: vernam_deciph_rx

Overview:
Downstream receive stage for the Vernam cipher encryptor.
- Accepts ciphertext bytes over a valid/ready handshake.
- Regenerates the same keystream with a local LFSR seeded identically to the transmit side.
- XORs each ciphertext byte with its key byte and buffers the recovered plaintext in a small FIFO for the consumer.
- Frames are bounded by a start pulse and a last-byte flag. The keystream restarts from SEED for every frame.

Parameters:
SEED, 8'hA5, keystream seed loaded at reset and at each frame start; must be nonzero.
DEPTH, 4, plaintext FIFO depth in bytes; power of 2, >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; begins a frame when in IDLE, ignored otherwise.
ct_in  input  8  ciphertext byte.
ct_valid  input  1  ct_in valid.
ct_last  input  1  qualifies ct_in as final byte of frame.
ct_ready  output  1  block can accept ct_in this cycle.
pt_out  output  8  recovered plaintext byte (FIFO head).
pt_valid  output  1  pt_out valid.
pt_ready  input  1  consumer accepts pt_out.
busy  output  1  high when state != IDLE.
key_dbg  output  8  current keystream byte, for debug/monitor.

Behaviour:
Reset (rst=1 at a clock edge):
- state=IDLE, LFSR=SEED, FIFO emptied.
- ct_ready=0, pt_valid=0, pt_out=8'h00, busy=0, key_dbg=SEED.
- Reset mid-frame discards all buffered bytes with no partial output.

LFSR (Galois, right shift):
- next = {1'b0,k[7:1]} ^ (k[0] ? 8'hB8 : 8'h00).
- Advances only on an accepted ct byte (ct_valid & ct_ready). Key for byte n is the LFSR value before the nth advance.
- Sequence from A5: A5, EA, 75, ...

Handshakes:
- ct_ready = (state==RUN) & ~fifo_full. Combinational from registered state; never depends on ct_valid.
- pt_valid = ~fifo_empty. pt_out is the FIFO head, driven from registered storage.

Datapath:
- On ct accept, push ct_in ^ key into FIFO in the same edge.
- Latency: pt_valid rises on the cycle after ct accept if the FIFO was empty.
- Push and pop in the same cycle are both allowed, including when full (push gated by ct_ready, so at full only the pop occurs that cycle; ct_ready reasserts the next cycle).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.

FSM:
- IDLE: start=1 -> RUN; LFSR reloaded with SEED on the same edge.
- RUN: accepted byte with ct_last=1 -> DRAIN.
- DRAIN: ct_ready=0; when FIFO empty (including same-cycle final pop) -> IDLE.
- start during RUN/DRAIN: ignored.
- ct_valid while not ready: held off, no state change.
- Illegal state encodings -> IDLE.

Optional Feature:
Macro VERNAM_RX_CHK_EN.
- Defined: adds output chk_out[7:0] and chk_valid[0:0].
  - chk_out is the running XOR of all plaintext bytes pushed this frame.
  - It clears to 0 on frame start and on rst.
  - chk_valid pulses one cycle on the DRAIN->IDLE transition, with chk_out holding the frame checksum.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package vernam_pkg: LFSR tap constant 8'hB8, state encodings (IDLE/RUN/DRAIN), byte width constant, and a function for one LFSR step. The encryptor reuses this package so both ends share one keystream definition.
- One sub-module, vernam_byte_fifo (DEPTH-parameterised, registered head, full/empty flags). The FSM, LFSR and XOR stay in the top.

Test Plan:
1. Reset, start, send ct 8'hCD (0x68^A5) with ct_last=1, pt_ready=1 -> pt_out=8'h68 ('h') one cycle later; busy falls after the drain; key_dbg returns to A5 only on the next start.
2. Encrypt "helloworld2" with the A5 keystream, feed back-to-back with ct_last on the final byte -> pt stream equals "helloworld2" byte-exact, no gaps once the first byte emerges.
3. pt_ready=0 and push 5 bytes with DEPTH=4 -> ct_ready drops after the 4th accept and the 5th is held. Release pt_ready -> all 5 recovered in order, correct keys (A5, EA, 75, ...).
4. rst asserted mid-frame with 2 bytes buffered -> next cycle pt_valid=0, busy=0. A new frame restarts the keystream at A5.
5. start pulsed during RUN and during DRAIN -> ignored: LFSR not reseeded, output unaffected.
6. With VERNAM_RX_CHK_EN, frame "hi" (0x68, 0x69) -> chk_valid one-cycle pulse with chk_out=8'h01.
